// File: rtl/stage_sum_pkg.sv
// Shared types and default widths for the stage-sum read-port requester.
// Saturation limits are used only when STAGE_SUM_SAT_EN is defined.
package stage_sum_pkg;

  localparam int W_DATA_DEF  = 13;
  localparam int W_ADDR_DEF  = 12;
  localparam int W_CNT_DEF   = 8;
  localparam int W_SUM_DEF   = 20;
  localparam int MAX_OUT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/stage_sum_credit.sv
// Up/down outstanding-request counter; can_issue_o is high while the count
// is below LIMIT. Shared by the read-port requesters.
module out_credit #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic can_issue_o
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q, count_d;

  // next outstanding count: simultaneous inc and dec cancel, never below zero
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = {W{1'b0}};
    end else if (inc_i && !dec_i) begin
      count_d = count_q + W'(1);
    end else if (dec_i && !inc_i && (count_q != {W{1'b0}})) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign can_issue_o = (count_q < W'(LIMIT));

endmodule

// File: rtl/stage_sum.sv
// Stage-sum requester: issues len consecutive reads from base and sums the
// signed replies. Define STAGE_SUM_SAT_EN for a sticky saturating accumulator.
module stage_sum
  import stage_sum_pkg::*;
#(
  parameter int W_DATA  = W_DATA_DEF,
  parameter int W_ADDR  = W_ADDR_DEF,
  parameter int W_CNT   = W_CNT_DEF,
  parameter int W_SUM   = W_SUM_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W_ADDR-1:0] cmd_base,
  input  logic [W_CNT-1:0]  cmd_len,
  output logic              addr1_valid,
  input  logic              addr1_ready,
  output logic [W_ADDR-1:0] addr1_data,
  input  logic              data1_valid,
  output logic              data1_ready,
  input  logic [W_DATA-1:0] data1,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [W_SUM-1:0]  sum_data
);

  state_e            state_q, state_d;
  logic [W_ADDR-1:0] base_q, base_d;
  logic [W_CNT-1:0]  len_q, len_d;
  logic [W_CNT-1:0]  issued_q, issued_d;
  logic [W_CNT-1:0]  recv_q, recv_d;
  logic [W_SUM-1:0]  acc_q, acc_d;
  logic [W_SUM-1:0]  data_ext_s;
  logic [W_SUM-1:0]  acc_add_s;
  logic              cmd_fire_s, addr_fire_s, data_fire_s, can_issue_s;

  assign cmd_fire_s  = cmd_valid & cmd_ready;
  assign addr_fire_s = addr1_valid & addr1_ready;
  assign data_fire_s = data1_valid & data1_ready;
  assign data_ext_s  = {{(W_SUM - W_DATA){data1[W_DATA-1]}}, data1};

`ifdef STAGE_SUM_SAT_EN
  localparam logic [W_SUM-1:0] SAT_MAX = W_SUM'(sat_max(W_SUM));
  localparam logic [W_SUM-1:0] SAT_MIN = W_SUM'(sat_min(W_SUM));

  logic [W_SUM:0] wide_s;
  logic           sat_hit_s;
  logic           sat_q;

  // saturating add; once clamped the accumulator stays put for this command
  always_comb begin
    wide_s    = {acc_q[W_SUM-1], acc_q} + {data_ext_s[W_SUM-1], data_ext_s};
    sat_hit_s = 1'b0;
    acc_add_s = wide_s[W_SUM-1:0];
    if (sat_q) begin
      acc_add_s = acc_q;
    end else if (wide_s[W_SUM] != wide_s[W_SUM-1]) begin
      sat_hit_s = 1'b1;
      acc_add_s = wide_s[W_SUM] ? SAT_MIN : SAT_MAX;
    end else begin
      acc_add_s = wide_s[W_SUM-1:0];
    end
  end

  // sticky saturation flag, cleared by each new command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (cmd_fire_s) begin
      sat_q <= 1'b0;
    end else if (data_fire_s && sat_hit_s) begin
      sat_q <= 1'b1;
    end else begin
      sat_q <= sat_q;
    end
  end
`else
  assign acc_add_s = acc_q + data_ext_s;
`endif

  out_credit #(
    .LIMIT(MAX_OUT)
  ) u_credit (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (cmd_fire_s),
    .inc_i      (addr_fire_s),
    .dec_i      (data_fire_s),
    .can_issue_o(can_issue_s)
  );

  // next-state and datapath: len==0 still spends one cycle in RUN
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    issued_d = issued_q;
    recv_d   = recv_q;
    acc_d    = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_s) begin
          base_d   = cmd_base;
          len_d    = cmd_len;
          issued_d = {W_CNT{1'b0}};
          recv_d   = {W_CNT{1'b0}};
          acc_d    = {W_SUM{1'b0}};
          state_d  = ST_RUN;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (addr_fire_s) begin
          issued_d = issued_q + W_CNT'(1);
        end else begin
          issued_d = issued_q;
        end
        if (len_q == {W_CNT{1'b0}}) begin
          state_d = ST_DONE;
        end else if (data_fire_s) begin
          acc_d  = acc_add_s;
          recv_d = recv_q + W_CNT'(1);
          if (recv_q == (len_q - W_CNT'(1))) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (sum_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      base_q   <= {W_ADDR{1'b0}};
      len_q    <= {W_CNT{1'b0}};
      issued_q <= {W_CNT{1'b0}};
      recv_q   <= {W_CNT{1'b0}};
      acc_q    <= {W_SUM{1'b0}};
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      acc_q    <= acc_d;
    end
  end

  // outputs decode from registered state only
  assign cmd_ready   = (state_q == ST_IDLE);
  assign data1_ready = (state_q == ST_RUN);
  assign sum_valid   = (state_q == ST_DONE);
  assign addr1_valid = (state_q == ST_RUN) && (issued_q < len_q) && can_issue_s;
  assign addr1_data  = base_q + W_ADDR'(issued_q);
  assign sum_data    = acc_q;

endmodule

// File: tb/tb_stage_sum.sv
// Self-checking bench for stage_sum: a latency-2 read-port model with
// optional stalls, a directed vector table, random commands and a mid-run reset.
module tb_stage_sum;

  localparam int W_SUM   = 20;
  localparam int MAX_OUT = 4;
  localparam int L_RD    = 2;
  localparam longint SMAX = (longint'(1) << (W_SUM - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W_SUM - 1));
`ifdef STAGE_SUM_SAT_EN
  localparam logic [W_SUM-1:0] EXP255 = 20'h80000;
`else
  // 255 * -4096 needs 21 bits, so the 20-bit sum wraps to +4096
  localparam logic [W_SUM-1:0] EXP255 = 20'h01000;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_base = 12'h000;
  logic [7:0]  cmd_len = 8'd0;
  logic        addr1_valid;
  logic        addr1_ready = 1'b1;
  logic [11:0] addr1_data;
  logic        data1_valid = 1'b0;
  logic        data1_ready;
  logic [12:0] data1 = 13'h0000;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic [19:0] sum_data;

  stage_sum dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .addr1_valid(addr1_valid), .addr1_ready(addr1_ready), .addr1_data(addr1_data),
    .data1_valid(data1_valid), .data1_ready(data1_ready), .data1(data1),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] a; int t; } req_t;
  typedef struct { logic [11:0] base; logic [7:0] len; int lat; logic [19:0] sum; string name; } vec_t;

  logic [12:0] mem [4096];
  req_t        pend [$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          outst = 0;
  int          max_out_seen = 0;
  int          n_issued = 0;
  int          cur_len = 0;
  logic [11:0] cur_base = 12'h000;
  bit          consumed = 1'b0;
  bit          rand_ar = 1'b0;
  bit          rand_stall = 1'b0;
  int          stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // reference: plain signed sum over the address range, wrapped or clamped
  function automatic logic [W_SUM-1:0] ref_sum(input logic [11:0] base, input int len);
    longint      s = 0;
    logic [11:0] a;
`ifdef STAGE_SUM_SAT_EN
    bit          sat = 1'b0;
`endif
    for (int i = 0; i < len; i++) begin
      a = base + 12'(i);
`ifdef STAGE_SUM_SAT_EN
      if (!sat) begin
        s += longint'($signed(mem[a]));
        if (s > SMAX) begin s = SMAX; sat = 1'b1; end
        else if (s < SMIN) begin s = SMIN; sat = 1'b1; end
      end
`else
      s += longint'($signed(mem[a]));
`endif
    end
    return s[W_SUM-1:0];
  endfunction

  // monitor: sees pre-edge values of every handshake
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      outst = 0;
      n_issued = 0;
    end else begin
      if (addr1_valid && addr1_ready) begin
        chk("addr_value", {20'd0, addr1_data}, {20'd0, cur_base + 12'(n_issued)});
        chk("addr_in_range", 32'(n_issued < cur_len), 32'd1);
        pend.push_back('{addr1_data, cyc + L_RD - 1});
        n_issued++;
        outst++;
      end
      if (data1_valid && data1_ready) begin
        consumed = 1'b1;
        outst--;
      end
      if (outst > max_out_seen) max_out_seen = outst;
    end
  end

  // read-port model: in-order, round trip L_RD, optional output stalls
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      data1_valid = 1'b0;
      consumed = 1'b0;
      stall_cnt = 0;
    end else begin
      if (consumed) begin
        data1_valid = 1'b0;
        consumed = 1'b0;
      end
      if (stall_cnt > 0) stall_cnt--;
      else if (rand_stall && !data1_valid && $urandom_range(0, 5) == 0) stall_cnt = 3;
      if (!data1_valid && stall_cnt == 0 && pend.size() > 0 && pend[0].t <= cyc) begin
        data1 = mem[pend[0].a];
        data1_valid = 1'b1;
        void'(pend.pop_front());
      end
      addr1_ready = rand_ar ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // called and returning on a negedge
  task automatic run_cmd(input logic [11:0] base, input logic [7:0] len, input int exp_lat,
                         input logic [19:0] exp_sum, input string name, input int hold);
    int k;
    int lat;
    cur_base = base;
    cur_len = int'(len);
    n_issued = 0;
    cmd_base = base;
    cmd_len = len;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    chk({name, "_cmd_accept"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!sum_valid && lat < 1000) begin @(negedge clk); lat++; end
    chk({name, "_sum_valid"}, 32'(sum_valid), 32'd1);
    if (exp_lat >= 0) chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_sum"}, {12'd0, sum_data}, {12'd0, exp_sum});
    repeat (hold) @(negedge clk);
    chk({name, "_sum_hold"}, {11'd0, sum_valid, sum_data}, {11'd0, 1'b1, exp_sum});
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    chk({name, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    chk({name, "_addr_count"}, 32'(n_issued), 32'(len));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [4];
    logic [11:0] b;
    logic [7:0]  n;
    int          k;

    for (int i = 0; i < 4096; i++) mem[i] = 13'($urandom);
    mem[12'h010] = 13'd5;  mem[12'h011] = 13'h1FFD; mem[12'h012] = 13'd7; mem[12'h013] = 13'd1;
    mem[12'hFFE] = 13'd100; mem[12'hFFF] = 13'h1FCE; mem[12'h000] = 13'd7;
    for (int i = 0; i < 255; i++) mem[12'h100 + 12'(i)] = 13'h1000;

    vecs[0] = '{12'h010, 8'd4,   7,   20'd10, "len4"};
    vecs[1] = '{12'h345, 8'd0,   2,   20'd0,  "len0"};
    vecs[2] = '{12'hFFE, 8'd3,   6,   20'd57, "wrap"};
    vecs[3] = '{12'h100, 8'd255, 258, EXP255, "len255"};

    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_addr1_valid", 32'(addr1_valid), 32'd0);
    chk("rst_data1_ready", 32'(data1_ready), 32'd0);
    chk("rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("rst_sum_data", {12'd0, sum_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_cmd(vecs[i].base, vecs[i].len, vecs[i].lat, vecs[i].sum, vecs[i].name, 1);

    rand_ar = 1'b1;
    rand_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b = 12'($urandom);
      n = 8'($urandom_range(0, 40));
      run_cmd(b, n, -1, ref_sum(b, int'(n)), "rnd", $urandom_range(0, 3));
    end
    rand_ar = 1'b0;
    rand_stall = 1'b0;
    chk("outstanding_le_max", 32'(max_out_seen <= MAX_OUT), 32'd1);

    // reset mid-RUN with two requests in flight
    cur_base = 12'h200;
    cur_len = 20;
    n_issued = 0;
    cmd_base = 12'h200;
    cmd_len = 8'd20;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (outst < 2 && k < 20) begin @(negedge clk); k++; end
    chk("rst_mid_outstanding", 32'(outst), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_addr1_valid", 32'(addr1_valid), 32'd0);
    chk("rst_mid_data1_ready", 32'(data1_ready), 32'd0);
    chk("rst_mid_sum_valid", 32'(sum_valid), 32'd0);
    chk("rst_mid_sum_data", {12'd0, sum_data}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd(12'h200, 8'd20, 23, ref_sum(12'h200, 20), "post_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
